alu_multicycle: RTL and testbench

//  Parametrised next-generation datapath ALU: registered single-cycle integer ops plus iterative

---
 rtl/ctrl_encode_def.sv | 43 ++++
 rtl/alu_muldiv_iter.sv | 147 ++++++++++++++
 rtl/alu_multicycle.sv | 143 ++++++++++++++
 tb/tb_alu_multicycle.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_encode_def.sv
// ============================================================================
// ctrl_encode_def : shared ALU opcode encoding and multicycle FSM states
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ctrl_encode_def;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] ALU_NOP   = 5'd0;
  localparam logic [OP_W-1:0] ALU_ADD   = 5'd1;
  localparam logic [OP_W-1:0] ALU_SUB   = 5'd2;
  localparam logic [OP_W-1:0] ALU_AND   = 5'd3;
  localparam logic [OP_W-1:0] ALU_OR    = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLT   = 5'd5;
  localparam logic [OP_W-1:0] ALU_SLTU  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SLL   = 5'd7;
  localparam logic [OP_W-1:0] ALU_SRL   = 5'd8;
  localparam logic [OP_W-1:0] ALU_SRA   = 5'd9;
  localparam logic [OP_W-1:0] ALU_NOR   = 5'd10;
  localparam logic [OP_W-1:0] ALU_XOR   = 5'd11;
  localparam logic [OP_W-1:0] ALU_IMM   = 5'd12;
  localparam logic [OP_W-1:0] ALU_MULT  = 5'd13;
  localparam logic [OP_W-1:0] ALU_MULTU = 5'd14;
  localparam logic [OP_W-1:0] ALU_DIV   = 5'd15;
  localparam logic [OP_W-1:0] ALU_DIVU  = 5'd16;
  localparam logic [OP_W-1:0] ALU_MFHI  = 5'd17;
  localparam logic [OP_W-1:0] ALU_MFLO  = 5'd18;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic is_muldiv_op(input logic [OP_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// alu_muldiv_iter : iterative radix-2 multiply / restoring divide with HI/LO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_muldiv_iter
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             kill_i,
  input  logic [OP_W-1:0]  opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, rem_sh;
  logic [WIDTH-1:0] mul_acc, mul_sh, div_acc, div_sh;
  logic             ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_signed = (opcode_i == ALU_MULT) || (opcode_i == ALU_DIV);
  assign op_div    = (opcode_i == ALU_DIV) || (opcode_i == ALU_DIVU);
  assign a_neg     = op_signed & a_i[WIDTH-1];
  assign b_neg     = op_signed & b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  // One shift-add step: acc holds the running high half, sh the multiplier/low half.
  assign add_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_acc = add_sum[WIDTH:1];
  assign mul_sh  = {add_sum[0], sh_q[WIDTH-1:1]};

  // One restoring step: acc is the partial remainder, sh shifts dividend out and quotient in.
  assign rem_sh  = {acc_q, sh_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, opb_q});
  assign div_acc = ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
  assign div_sh  = {sh_q[WIDTH-2:0], ge};

  assign prod     = {mul_acc, mul_sh};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (dz_q) begin
        res_lo = '1;
        res_hi = dvd_q;
      end else begin
        res_lo = neg_q  ? -div_sh  : div_sh;
        res_hi = rneg_q ? -div_acc : div_acc;
      end
    end
  end

  assign last_o = run_i && (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    opb_d  = opb_q;
    dvd_d  = dvd_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (load_i) begin
      cnt_d  = '0;
      acc_d  = '0;
      sh_d   = a_mag;
      opb_d  = b_mag;
      dvd_d  = a_i;
      div_d  = op_div;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = op_div && (b_i == '0);
    end else if (run_i && !kill_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = div_q ? div_acc : mul_acc;
      sh_d  = div_q ? div_sh  : mul_sh;
      if (last_o) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opb_q  <= '0;
      dvd_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opb_q  <= opb_d;
      dvd_q  <= dvd_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign res_lo_o = res_lo;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ============================================================================
// alu_multicycle : registered single-cycle ALU plus iterative mul/div (HI/LO)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_multicycle
  import ctrl_encode_def::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             kill,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d, done_q, done_d;
  logic             md_load, md_start, md_last;
  logic [WIDTH-1:0] md_res_lo, hi_w, lo_w, alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign shamt    = A[SHAMT_W-1:0];
  assign md_start = MULDIV_EN && is_muldiv_op(opcode);

  always_comb begin
    alu_res = A;
    case (opcode)
      ALU_ADD:  alu_res = A + B;
      ALU_SUB:  alu_res = A - B;
      ALU_AND:  alu_res = A & B;
      ALU_OR:   alu_res = A | B;
      ALU_NOR:  alu_res = ~(A | B);
      ALU_XOR:  alu_res = A ^ B;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_IMM:  alu_res = B;
      ALU_SLL:  alu_res = B << shamt;
      ALU_SRL:  alu_res = B >> shamt;
      ALU_SRA:  alu_res = $signed(B) >>> shamt;
      ALU_MFHI: alu_res = MULDIV_EN ? hi_w : A;
      ALU_MFLO: alu_res = MULDIV_EN ? lo_w : A;
      default:  alu_res = A;
    endcase
  end

  generate
    if (MULDIV_EN) begin : g_muldiv
      alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rstn     (rstn),
        .load_i   (md_load),
        .run_i    (state_q == S_RUN),
        .kill_i   (kill),
        .opcode_i (opcode),
        .a_i      (A),
        .b_i      (B),
        .last_o   (md_last),
        .res_lo_o (md_res_lo),
        .hi_o     (hi_w),
        .lo_o     (lo_w)
      );
    end else begin : g_no_muldiv
      assign md_last   = 1'b0;
      assign md_res_lo = '0;
      assign hi_w      = '0;
      assign lo_w      = '0;
    end
  endgenerate

  // kill outranks completion so an aborted op never signals done.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    md_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (md_start) begin
            md_load = 1'b1;
            state_d = S_RUN;
          end else begin
            c_d    = alu_res;
            zero_d = (alu_res == '0);
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (md_last) begin
          state_d = S_IDLE;
          c_d     = md_res_lo;
          zero_d  = (md_res_lo == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign C    = c_q;
  assign Zero = zero_q;
  assign done = done_q;
  assign busy = (state_q == S_RUN);
  assign hi   = hi_w;
  assign lo   = lo_w;

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ============================================================================
// tb_alu_multicycle : directed self-checking bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_multicycle;
  import ctrl_encode_def::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [4:0]   opcode = 5'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] C, hi, lo;
  logic         Zero, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .kill   (kill),
    .opcode (opcode),
    .A      (A),
    .B      (B),
    .C      (C),
    .Zero   (Zero),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]   m_C = '0, m_hi = '0, m_lo = '0;
  logic           m_Z = 1'b0, m_done = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_pend = '0;

  function automatic logic [W-1:0] alu_ref(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] h,
                                           input logic [W-1:0] l);
    int sa, sb;
    logic [4:0] sh;
    sa = a;
    sb = b;
    sh = a[4:0];
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_NOR:  return ~(a | b);
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_IMM:  return b;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return 32'(sb >>> sh);
      ALU_MFHI: return h;
      ALU_MFLO: return l;
      default:  return a;
    endcase
  endfunction

  // Returns {hi, lo} for a mul/div op using plain integer arithmetic.
  function automatic logic [2*W-1:0] md_ref(input logic [4:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint pa, pb;
    int sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      ALU_MULT: begin
        pa = longint'(sa);
        pb = longint'(sb);
        return 64'(pa * pb);
      end
      ALU_MULTU: return {32'd0, a} * {32'd0, b};
      ALU_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic is_md(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_C <= '0; m_Z <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (kill) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_C    <= m_pend[31:0];
            m_Z    <= (m_pend[31:0] == 0);
            m_done <= 1'b1;
          end
        end
      end else if (start) begin
        if (is_md(opcode)) begin
          m_pend <= md_ref(opcode, A, B);
          m_left <= W;
        end else begin
          m_C    <= alu_ref(opcode, A, B, m_hi, m_lo);
          m_Z    <= (alu_ref(opcode, A, B, m_hi, m_lo) == 0);
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("C", C, m_C);
    check("Zero", W'(Zero), W'(m_Z));
    check("done", W'(done), W'(m_done));
    check("busy", W'(busy), W'(m_left != 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; opcode = 5'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      opcode = 5'($urandom); A = $urandom; B = $urandom;
    end
    check("wait_done_timeout", W'(done), 32'd1);
  endtask

  int cyc;
  logic [4:0]   bb_op [6] = '{ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL};
  logic [W-1:0] bb_a  [6] = '{32'hF0F0_1234, 32'h0000_00FF, 32'h1234_0000, 32'hAAAA_5555, 32'd31, 32'd8};
  logic [W-1:0] bb_b  [6] = '{32'h0FF0_FF00, 32'hFF00_0000, 32'h0000_5678, 32'h5555_AAAA, 32'd3, 32'h8000_0000};

  initial begin
    #2 rstn = 1'b0;
    #1;
    check("rst_C", C, 32'd0);
    check("rst_Zero", W'(Zero), 32'd0);
    check("rst_busy", W'(busy), 32'd0);
    check("rst_done", W'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    issue(ALU_ADD, 32'h7FFFFFFF, 32'd1);
    check("add_C", C, 32'h80000000);
    check("add_Zero", W'(Zero), 32'd0);
    check("add_done", W'(done), 32'd1);
    check("add_busy", W'(busy), 32'd0);
    issue(ALU_SUB, 32'd5, 32'd5);
    check("sub_C", C, 32'd0);
    check("sub_Zero", W'(Zero), 32'd1);
    issue(ALU_SRA, 32'h24, 32'h80000000);
    check("sra_C", C, 32'hF8000000);
    issue(ALU_SLT, 32'hFFFFFFFF, 32'd1);
    check("slt_C", C, 32'd1);
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'd1);
    check("sltu_C", C, 32'd0);
    issue(ALU_IMM, 32'd7, 32'hCAFE0000);
    check("imm_C", C, 32'hCAFE0000);
    issue(5'd31, 32'h1357_9BDF, 32'd9);
    check("undef_C", C, 32'h1357_9BDF);

    // start and kill together in IDLE: start wins
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; opcode = ALU_ADD; A = 32'd10; B = 32'd20;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("startkill_C", C, 32'd30);

    // back-to-back single-cycle ops
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = bb_op[i]; A = bb_a[i]; B = bb_b[i];
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b_last_C", C, 32'h0080_0000);

    issue(ALU_MULT, 32'hFFFFFFFD, 32'd5);
    check("mult_busy", W'(busy), 32'd1);
    wait_done(cyc);
    check("mult_latency", 32'(cyc), 32'd32);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);
    check("mult_C", C, 32'hFFFFFFF1);
    issue(ALU_MFHI, 32'd0, 32'd0);
    check("mfhi_C", C, 32'hFFFFFFFF);
    issue(ALU_MFLO, 32'd0, 32'd0);
    check("mflo_C", C, 32'hFFFFFFF1);

    issue(ALU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    issue(ALU_DIVU, 32'd7, 32'd0);
    wait_done(cyc);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    check("divu0_hi", hi, 32'd7);
    issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 32'd0);
    issue(ALU_DIV, 32'hFFFFFFF8, 32'd0);
    wait_done(cyc);
    check("div0s_lo", lo, 32'hFFFFFFFF);
    check("div0s_hi", hi, 32'hFFFFFFF8);
    issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    issue(ALU_MULT, 32'h80000000, 32'h80000000);
    wait_done(cyc);
    check("multmin_hi", hi, 32'h40000000);
    check("multmin_Zero", W'(Zero), 32'd1);

    // kill during MULTU; a start while busy is ignored
    issue(ALU_MULTU, 32'h0000FFFF, 32'h00001234);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      opcode = ALU_ADD;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("kill_pre_busy", W'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", W'(busy), 32'd0);
    check("kill_done", W'(done), 32'd0);
    check("kill_hi", hi, 32'h40000000);
    check("kill_lo", lo, 32'd0);
    issue(ALU_ADD, 32'd2, 32'd3);
    check("postkill_C", C, 32'd5);
    check("postkill_done", W'(done), 32'd1);

    // asynchronous reset mid-divide
    issue(ALU_DIV, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1;
    check("arst_C", C, 32'd0);
    check("arst_busy", W'(busy), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    issue(ALU_DIVU, 32'd9, 32'd3);
    wait_done(cyc);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
